// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed-bus cycle engine.
// Holds the bus FSM states, the idle strobe pattern and the default phase length.
package rtc_bus_pkg;

   localparam int PHASE_CYC_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ADDR    = 3'd1,
      ST_ALATCH  = 3'd2,
      ST_GAP     = 3'd3,
      ST_DATA    = 3'd4,
      ST_RELEASE = 3'd5,
      ST_DONE    = 3'd6
   } state_t;

   typedef struct packed {
      logic cs_n;
      logic rd_n;
      logic wr_n;
      logic ad_n;
   } strobe_t;

   localparam strobe_t STROBE_IDLE = 4'b1111;

   // Fixed order of the timed bus phases; anything unexpected falls back to IDLE.
   function automatic state_t next_phase(input state_t s);
      state_t n;
      case (s)
         ST_IDLE:    n = ST_ADDR;
         ST_ADDR:    n = ST_ALATCH;
         ST_ALATCH:  n = ST_GAP;
         ST_GAP:     n = ST_DATA;
         ST_DATA:    n = ST_RELEASE;
         ST_RELEASE: n = ST_DONE;
         default:    n = ST_IDLE;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/rtc_bus_cycle_if.sv
// Command-side handshake plus RTC chip pins for one bus-cycle engine.
// The slave modport is the engine; the master modport is the command FSM and pad.
interface rtc_bus_cycle_if #(
   parameter int AW = 8,
   parameter int DW = 8
) ();

   logic          req;
   logic          rw;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          busy;
   logic          ack;
   logic [DW-1:0] rdata;
   logic          cs_n;
   logic          rd_n;
   logic          wr_n;
   logic          ad_n;
   logic [DW-1:0] ad_out;
   logic          ad_oe;
   logic [DW-1:0] ad_in;

   modport master (
      output req, rw, addr, wdata, ad_in,
      input  busy, ack, rdata, cs_n, rd_n, wr_n, ad_n, ad_out, ad_oe
   );

   modport slave (
      input  req, rw, addr, wdata, ad_in,
      output busy, ack, rdata, cs_n, rd_n, wr_n, ad_n, ad_out, ad_oe
   );

endinterface

// File: rtl/rtc_phase_timer.sv
// Phase length timer: reloads on every state change and counts down to zero.
// last_cyc is high during the final cycle of the current phase.
module rtc_phase_timer
   import rtc_bus_pkg::*;
#(
   parameter int PHASE_CYC = PHASE_CYC_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic last_cyc
);

   localparam int CW = $clog2(PHASE_CYC + 1);
   localparam logic [CW-1:0] RELOAD = CW'(PHASE_CYC - 1);

   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;

   // Holds at zero instead of wrapping, so a stalled phase never re-times itself.
   always_comb begin
      cnt_next = cnt_reg;
      if (load) begin
         cnt_next = RELOAD;
      end else if (cnt_reg != '0) begin
         cnt_next = cnt_reg - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign last_cyc = (cnt_reg == '0);

endmodule

// File: rtl/rtc_bus_cycle.sv
// Bus-cycle engine: one read or write per req/ack handshake on the RTC's
// multiplexed address/data bus, with every pin driven straight from a flop.
module rtc_bus_cycle
   import rtc_bus_pkg::*;
#(
   parameter int PHASE_CYC = PHASE_CYC_DEF,
   parameter int AW        = 8,
   parameter int DW        = 8
) (
   input logic            clk,
   input logic            reset,
   rtc_bus_cycle_if.slave bus
);

   state_t        state_reg;
   state_t        state_next;
   logic          last_cyc;
   logic          phase_load;
   logic          accept;

   logic          rw_reg;
   logic [AW-1:0] addr_reg;
   logic [DW-1:0] wdata_reg;
   logic [DW-1:0] addr_dw;
   logic [DW-1:0] rdata_reg;
   logic          cap_reg;
   logic          cap_next;

   strobe_t       strobe_reg;
   strobe_t       strobe_next;
   logic [DW-1:0] ad_out_reg;
   logic [DW-1:0] ad_out_next;
   logic          ad_oe_reg;
   logic          ad_oe_next;
   logic          busy_reg;
   logic          busy_next;
   logic          ack_reg;
   logic          ack_next;

   assign addr_dw = DW'(addr_reg);

   rtc_phase_timer #(
      .PHASE_CYC (PHASE_CYC)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (phase_load),
      .last_cyc (last_cyc)
   );

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (bus.req) begin
               state_next = ST_ADDR;
               accept     = 1'b1;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: begin
            if (last_cyc) begin
               state_next = next_phase(state_reg);
            end
         end
      endcase
      phase_load = (state_next != state_reg);
      // Bus outputs trail the state by a cycle, so the final visible DATA
      // cycle is sampled one edge after the DATA state's last cycle.
      cap_next   = (state_reg == ST_DATA) && last_cyc && rw_reg;
   end

   always_comb begin
      strobe_next = STROBE_IDLE;
      ad_out_next = '0;
      ad_oe_next  = 1'b0;
      busy_next   = (state_reg != ST_IDLE);
      ack_next    = (state_reg == ST_DONE);
      case (state_reg)
         ST_ADDR: begin
            strobe_next = '{cs_n: 1'b0, rd_n: 1'b1, wr_n: 1'b0, ad_n: 1'b0};
            ad_out_next = addr_dw;
            ad_oe_next  = 1'b1;
         end
         ST_ALATCH: begin
            strobe_next = '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, ad_n: 1'b0};
            ad_out_next = addr_dw;
            ad_oe_next  = 1'b1;
         end
         ST_DATA: begin
            if (rw_reg) begin
               strobe_next = '{cs_n: 1'b0, rd_n: 1'b0, wr_n: 1'b1, ad_n: 1'b1};
            end else begin
               strobe_next = '{cs_n: 1'b0, rd_n: 1'b1, wr_n: 1'b0, ad_n: 1'b1};
               ad_out_next = wdata_reg;
               ad_oe_next  = 1'b1;
            end
         end
         ST_RELEASE: begin
            if (!rw_reg) begin
               ad_out_next = wdata_reg;
               ad_oe_next  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= ST_IDLE;
         rw_reg     <= 1'b0;
         addr_reg   <= '0;
         wdata_reg  <= '0;
         rdata_reg  <= '0;
         cap_reg    <= 1'b0;
         strobe_reg <= STROBE_IDLE;
         ad_out_reg <= '0;
         ad_oe_reg  <= 1'b0;
         busy_reg   <= 1'b0;
         ack_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            rw_reg    <= bus.rw;
            addr_reg  <= bus.addr;
            wdata_reg <= bus.wdata;
         end
         cap_reg <= cap_next;
         if (cap_reg) begin
            rdata_reg <= bus.ad_in;
         end
         strobe_reg <= strobe_next;
         ad_out_reg <= ad_out_next;
         ad_oe_reg  <= ad_oe_next;
         busy_reg   <= busy_next;
         ack_reg    <= ack_next;
      end
   end

   assign bus.busy   = busy_reg;
   assign bus.ack    = ack_reg;
   assign bus.rdata  = rdata_reg;
   assign bus.cs_n   = strobe_reg.cs_n;
   assign bus.rd_n   = strobe_reg.rd_n;
   assign bus.wr_n   = strobe_reg.wr_n;
   assign bus.ad_n   = strobe_reg.ad_n;
   assign bus.ad_out = ad_out_reg;
   assign bus.ad_oe  = ad_oe_reg;

endmodule
